// File: rtl/bcd_updown_counter_n_if.sv
// Bundle of the control, bound and status signals of bcd_updown_counter_n.
//   master : drives en/up/load/load_val/init/limit (and sat_mode), observes status
//   slave  : the counter; drives count/carry/borrow/at_bound (and sat_flag)
// Optional feature macro: BCD_CNT_SATURATE_EN adds sat_mode / sat_flag.
interface bcd_updown_counter_n_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] init;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         carry;
  logic         borrow;
  logic         at_bound;
`ifdef BCD_CNT_SATURATE_EN
  logic         sat_mode;
  logic         sat_flag;

  modport master (
    output en, up, load, load_val, init, limit, sat_mode,
    input  count, carry, borrow, at_bound, sat_flag
  );

  modport slave (
    input  en, up, load, load_val, init, limit, sat_mode,
    output count, carry, borrow, at_bound, sat_flag
  );
`else
  modport master (
    output en, up, load, load_val, init, limit,
    input  count, carry, borrow, at_bound
  );

  modport slave (
    input  en, up, load, load_val, init, limit,
    output count, carry, borrow, at_bound
  );
`endif
endinterface

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit packed-BCD up/down counter with runtime bounds and 1-cycle wrap pulses.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (count=RST_VAL, pulses cleared)
//   bus    : bcd_updown_counter_n_if.slave
//            en, up, load, load_val, init, limit in; count, carry, borrow, at_bound out
// Parameters: DIGITS (1..8), RST_VAL (valid packed BCD).
// Optional feature macro: BCD_CNT_SATURATE_EN -- adds bus.sat_mode / bus.sat_flag; with
// sat_mode=1 the count holds at a bound instead of wrapping.
module bcd_updown_counter_n #(
  parameter int unsigned           DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]   RST_VAL = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  bcd_updown_counter_n_if.slave bus
);

  localparam int unsigned W = 4 * DIGITS;

  // Clamp every digit above 9 to 9 so count can never hold a non-BCD digit.
  function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;

  logic [W-1:0] load_s, init_s, limit_s;
  logic         at_top, at_bot;
  logic         sat_hold;

  assign load_s  = bcd_sanitise(bus.load_val);
  assign init_s  = bcd_sanitise(bus.init);
  assign limit_s = bcd_sanitise(bus.limit);

  // Plain unsigned compares; identical to decimal order for valid BCD.
  assign at_top = (count_q >= limit_s);
  assign at_bot = (count_q <= init_s);

`ifdef BCD_CNT_SATURATE_EN
  assign sat_hold = bus.sat_mode;
`else
  assign sat_hold = 1'b0;
`endif

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (bus.load) begin
      count_d = load_s;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!at_top) begin
          count_d = bcd_inc(count_q);
        end else if (!sat_hold) begin
          count_d = init_s;
          carry_d = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          count_d = bcd_dec(count_q);
        end else if (!sat_hold) begin
          count_d  = limit_s;
          borrow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= RST_VAL;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef BCD_CNT_SATURATE_EN
  logic sat_flag_q, sat_flag_d;

  // Set only while an enabled step is being held at a bound.
  always_comb begin
    sat_flag_d = 1'b0;
    if (!bus.load && bus.en && sat_hold) begin
      sat_flag_d = bus.up ? at_top : at_bot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign bus.sat_flag = sat_flag_q;
`endif

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.at_bound = bus.up ? at_top : at_bot;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n (DIGITS=2). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_bcd_updown_counter_n;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  bcd_updown_counter_n_if #(.DIGITS(2)) bus ();

  bcd_updown_counter_n #(
    .DIGITS  (2),
    .RST_VAL (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_value(input logic [7:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick(1);
    bus.load     = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    bus.init     = 8'h00;
    bus.limit    = 8'h59;
`ifdef BCD_CNT_SATURATE_EN
    bus.sat_mode = 1'b0;
`endif
    #12;
    check("rst_count", 32'(bus.count), 32'h00);
    check("rst_carry", 32'(bus.carry), 32'h0);
    check("rst_borrow", 32'(bus.borrow), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // 00..59 up with ripple and wrap
    bus.en = 1'b1;
    tick(9);
    check("up_09", 32'(bus.count), 32'h09);
    tick(1);
    check("up_ripple_10", 32'(bus.count), 32'h10);
    tick(49);
    check("up_59", 32'(bus.count), 32'h59);
    check("up_59_no_carry", 32'(bus.carry), 32'h0);
    check("up_at_bound", 32'(bus.at_bound), 32'h1);
    tick(1);
    check("up_wrap_00", 32'(bus.count), 32'h00);
    check("up_wrap_carry", 32'(bus.carry), 32'h1);
    tick(1);
    check("up_01", 32'(bus.count), 32'h01);
    check("carry_one_cycle", 32'(bus.carry), 32'h0);
    tick(59);
    check("sixty_steps", 32'(bus.count), 32'h00);
    check("sixty_carry", 32'(bus.carry), 32'h1);

    // async reset mid-count at 37
    bus.en = 1'b0;
    load_value(8'h36);
    bus.en = 1'b1;
    tick(1);
    check("mid_37", 32'(bus.count), 32'h37);
    rst_n = 1'b0;
    #2;
    check("async_rst_count", 32'(bus.count), 32'h00);
    check("async_rst_carry", 32'(bus.carry | bus.borrow), 32'h0);
    tick(1);
    check("rst_holds", 32'(bus.count), 32'h00);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    tick(1);
    check("post_rst_hold", 32'(bus.count), 32'h00);

    // down, init=05 limit=23, from 10
    bus.init  = 8'h05;
    bus.limit = 8'h23;
    bus.up    = 1'b0;
    load_value(8'h10);
    bus.en = 1'b1;
    tick(1);
    check("dn_ripple_09", 32'(bus.count), 32'h09);
    tick(4);
    check("dn_05", 32'(bus.count), 32'h05);
    check("dn_at_bound", 32'(bus.at_bound), 32'h1);
    tick(1);
    check("dn_wrap_23", 32'(bus.count), 32'h23);
    check("dn_borrow", 32'(bus.borrow), 32'h1);
    check("dn_no_carry", 32'(bus.carry), 32'h0);
    tick(1);
    check("dn_22", 32'(bus.count), 32'h22);
    check("borrow_one_cycle", 32'(bus.borrow), 32'h0);
    check("dn_not_bound", 32'(bus.at_bound), 32'h0);

    // load priority with sanitised digit, then hold
    bus.up       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'h4F;
    tick(1);
    bus.load = 1'b0;
    check("load_4F", 32'(bus.count), 32'h49);
    check("load_no_pulse", 32'({bus.carry, bus.borrow}), 32'h0);
    bus.en = 1'b0;
    tick(5);
    check("hold_49", 32'(bus.count), 32'h49);
    check("hold_no_pulse", 32'({bus.carry, bus.borrow}), 32'h0);

    // misprogrammed bounds init=30 limit=10
    bus.init  = 8'h30;
    bus.limit = 8'h10;
    load_value(8'h35);
    bus.en = 1'b1;
    tick(1);
    check("inv_up_30", 32'(bus.count), 32'h30);
    check("inv_up_carry", 32'(bus.carry), 32'h1);
    bus.en = 1'b0;
    bus.up = 1'b0;
    load_value(8'h05);
    bus.en = 1'b1;
    tick(1);
    check("inv_dn_10", 32'(bus.count), 32'h10);
    check("inv_dn_borrow", 32'(bus.borrow), 32'h1);

    // sanitised limit 5F acts as 59
    bus.en    = 1'b0;
    bus.up    = 1'b1;
    bus.init  = 8'h00;
    bus.limit = 8'h5F;
    load_value(8'h58);
    bus.en = 1'b1;
    tick(1);
    check("san_lim_59", 32'(bus.count), 32'h59);
    tick(1);
    check("san_lim_wrap", 32'(bus.count), 32'h00);
    check("san_lim_carry", 32'(bus.carry), 32'h1);

    // init == limit: carry every enabled step
    bus.init  = 8'h42;
    bus.limit = 8'h42;
    bus.en    = 1'b0;
    load_value(8'h42);
    bus.en = 1'b1;
    tick(2);
    check("eq_count", 32'(bus.count), 32'h42);
    check("eq_carry", 32'(bus.carry), 32'h1);

    // below init counting up proceeds normally
    bus.init  = 8'h20;
    bus.limit = 8'h30;
    bus.en    = 1'b0;
    load_value(8'h19);
    bus.en = 1'b1;
    tick(1);
    check("below_init_up", 32'(bus.count), 32'h20);
    check("below_init_nocarry", 32'(bus.carry), 32'h0);

`ifdef BCD_CNT_SATURATE_EN
    bus.init     = 8'h00;
    bus.limit    = 8'h59;
    bus.en       = 1'b0;
    load_value(8'h59);
    bus.sat_mode = 1'b1;
    bus.en       = 1'b1;
    tick(1);
    check("sat_hold_59", 32'(bus.count), 32'h59);
    check("sat_flag_set", 32'(bus.sat_flag), 32'h1);
    check("sat_no_carry", 32'(bus.carry), 32'h0);
    bus.up = 1'b0;
    tick(1);
    check("sat_dn_58", 32'(bus.count), 32'h58);
    check("sat_flag_clr", 32'(bus.sat_flag), 32'h0);
    bus.sat_mode = 1'b0;
`endif

    bus.en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
